// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
// Holds the FSM state encoding, wait-counter sizing and request decoding.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned MAX_WAIT_DEFAULT = 255;
    localparam int unsigned WAIT_CNT_W       = 8;

    // A port is requesting only when exactly one of read/write is high.
    function automatic logic is_requesting(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

    function automatic logic is_illegal(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around dmem_arbiter.
// slave is the arbiter's view; master is the view of the CPU/DMA/memory environment.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              read0;
    logic              write0;
    logic [ADDR_W-1:0] address0;
    logic [DATA_W-1:0] write_data0;
    logic [DATA_W-1:0] read_data0;
    logic              busy_wait0;

    logic              read1;
    logic              write1;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] write_data1;
    logic [DATA_W-1:0] read_data1;
    logic              busy_wait1;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_busy_wait;

    logic              err_timeout;
    logic              err_illegal;

    modport slave (
        input  read0, write0, address0, write_data0,
        output read_data0, busy_wait0,
        input  read1, write1, address1, write_data1,
        output read_data1, busy_wait1,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_busy_wait,
        output err_timeout, err_illegal
    );

    modport master (
        output read0, write0, address0, write_data0,
        input  read_data0, busy_wait0,
        output read1, write1, address1, write_data1,
        input  read_data1, busy_wait1,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_busy_wait,
        input  err_timeout, err_illegal
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on a tie
// and is moved to the port not granted last when a transaction retires.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~last_grant;
        end
    end

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        if (req0 && req1) begin
            grant_idx = ptr;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port (0) and a DMA port (1) onto one data memory,
// one transaction at a time, with a memory-wait timeout and illegal-request flag.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT - 1);

    state_t                state;
    state_t                state_next;

    logic                  grant_q;
    logic                  op_write_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  err_timeout_q;
    logic                  err_illegal_q;
    logic [DATA_W-1:0]     rdata0_q;
    logic [DATA_W-1:0]     rdata1_q;

    logic                  req0;
    logic                  req1;
    logic                  illegal_any;
    logic                  grant_valid;
    logic                  grant_idx;

    logic                  take_grant;
    logic                  capture;
    logic                  timeout_hit;
    logic                  cnt_inc;
    logic                  cmd_active;

    assign req0        = is_requesting(bus.read0, bus.write0);
    assign req1        = is_requesting(bus.read1, bus.write1);
    assign illegal_any = is_illegal(bus.read0, bus.write0) | is_illegal(bus.read1, bus.write1);

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .advance    (state == ST_DONE),
        .last_grant (grant_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take_grant  = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    take_grant = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over timeout when both occur in the same cycle.
                if (!bus.mem_busy_wait) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= 1'b0;
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wait_cnt      <= '0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            err_illegal_q <= illegal_any;
            if (take_grant) begin
                grant_q    <= grant_idx;
                op_write_q <= grant_idx ? bus.write1 : bus.write0;
                addr_q     <= grant_idx ? bus.address1 : bus.address0;
                wdata_q    <= grant_idx ? bus.write_data1 : bus.write_data0;
                wait_cnt   <= '0;
            end
            if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end
            if (capture && !op_write_q) begin
                if (grant_q) begin
                    rdata1_q <= bus.mem_read_data;
                end else begin
                    rdata0_q <= bus.mem_read_data;
                end
            end
        end
    end

    assign cmd_active = (state == ST_ISSUE) || (state == ST_WAIT);

    assign bus.mem_read       = cmd_active & ~op_write_q;
    assign bus.mem_write      = cmd_active & op_write_q;
    assign bus.mem_address    = cmd_active ? addr_q : '0;
    assign bus.mem_write_data = (cmd_active && op_write_q) ? wdata_q : '0;

    assign bus.busy_wait0 = req0 & ~((state == ST_DONE) && (grant_q == 1'b0));
    assign bus.busy_wait1 = req1 & ~((state == ST_DONE) && (grant_q == 1'b1));

    assign bus.read_data0  = rdata0_q;
    assign bus.read_data1  = rdata1_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_illegal = err_illegal_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter MAX_WAIT, default 255, memory-wait cycles before timeout; 8-bit counter.
REQ-004 Single clock clk; reset is synchronous and active-high, named reset; all state updates on posedge clk only.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 read0 / write0  input  1 each  requester 0 (CPU) read/write request.
REQ-008 address0  input  ADDR_W; write_data0  input  DATA_W  requester 0 address and write data.
REQ-009 read_data0  output  DATA_W; busy_wait0  output  1  requester 0 read result and stall.
REQ-010 read1, write1, address1, write_data1, read_data1, busy_wait1  same as port 0  requester 1 (DMA).
REQ-011 mem_read, mem_write  output  1; mem_address  output  ADDR_W; mem_write_data  output  DATA_W  memory-side command.
REQ-012 mem_read_data  input  DATA_W; mem_busy_wait  input  1  memory-side response.
REQ-013 err_timeout  output  1  sticky timeout flag; err_illegal  output  1  one-cycle pulse on read&write asserted together.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, DONE; one transaction in flight at a time.
REQ-015 Port N requesting = exactly one of readN/writeN high; both high = illegal, never granted, err_illegal pulses every cycle it holds.
REQ-016 IDLE: one requesting port -> grant it; both -> grant port not granted last (round-robin pointer); go ISSUE.
REQ-017 Grant latches port index, address, write data, and op into internal registers; later port-input changes ignored until DONE.
REQ-018 ISSUE (1 cycle): drive mem_read or mem_write high with latched address/data; go WAIT.
REQ-019 WAIT: hold command; on mem_busy_wait sampled low -> capture mem_read_data (reads only) into read_dataN, go DONE.
REQ-020 WAIT: wait counter increments each cycle mem_busy_wait high; at MAX_WAIT -> set err_timeout, drop command, go DONE with read_dataN unchanged.
REQ-021 DONE (1 cycle): mem_read/mem_write low; granted port's busy_waitN low; toggle round-robin pointer; go IDLE.
REQ-022 busy_waitN = requesting(N) and not (state==DONE and grant==N); combinational; low when port idle.
REQ-023 Requester deasserts request cycle after busy_waitN low; request still high in IDLE counts as new transaction.
REQ-024 Best-case latency: request cycle 0 -> ISSUE cycle 1 -> WAIT cycle 2 -> DONE cycle 3 (memory not busy).
REQ-025 mem_read and mem_write never high simultaneously; mem outputs zero outside ISSUE/WAIT.
REQ-026 read_dataN holds last completed read value until next read completes on that port.

Reset
REQ-027 reset: state IDLE, pointer favors port 0, counter 0, err_timeout 0, err_illegal 0, read_data0/1 0, all mem outputs 0.
REQ-028 reset mid-transaction aborts it, memory command deasserted next cycle, no read data captured.

Structure
REQ-029 Shared package holds FSM state encoding (2-bit) and MAX_WAIT default.
REQ-030 Sub-module rr_arb2 (2-way round-robin arbiter with pointer) instantiated once; rest in dmem_arbiter.

Verification
REQ-031 Port 0 write addr 0x10 data 0xA5, memory busy 3 cycles -> mem_write high 4 cycles, busy_wait0 low on DONE, memory[0x10]=0xA5.
REQ-032 Both ports read simultaneously after reset -> port 0 served first, then port 1; each read_dataN matches memory contents.
REQ-033 Both ports request continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-034 mem_busy_wait stuck high -> err_timeout set after 255 wait cycles, busy_wait0 released, read_data0 unchanged.
REQ-035 read1 and write1 high together -> err_illegal pulses, no memory command issued, port 0 unaffected.
REQ-036 reset asserted during WAIT -> next cycle IDLE, mem_read 0, outputs at reset values.
